vpu_cmd_dispatcher: RTL and testbench

//   Command queue and dispatcher upstream of the VPU request interface.
//   The host pushes vector commands into a DEPTH-entry FIFO. The dispatcher issues them one at a time
//   to the VPU decoder with a valid/ready handshake. It holds the next command until the VPU signals

---
 rtl/vpu_cmd_dispatcher.sv | 170 +++++++++++++++++
 tb/tb_vpu_cmd_dispatcher.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vpu_cmd_dispatcher.sv
// vpu_cmd_dispatcher: host command FIFO feeding the VPU decoder, at most one command in flight.
// Latency: push edge N -> req_valid_o after edge N+1; next command issues on the edge that samples done_i.
// Backpressure: cmd_ready_o drops while the FIFO is full; req_* hold until req_ready_i. Watchdog: VPU_CMD_TIMEOUT_EN.
module vpu_cmd_dispatcher #(
    parameter int DEPTH    = 4,
    parameter int OPCODE_W = 8,
    parameter int ADDR_W   = 16
`ifdef VPU_CMD_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 1024
`endif
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cmd_valid_i,
    output logic                       cmd_ready_o,
    input  logic [OPCODE_W-1:0]        cmd_opcode_i,
    input  logic [ADDR_W-1:0]          cmd_src0_i,
    input  logic [ADDR_W-1:0]          cmd_src1_i,
    input  logic [ADDR_W-1:0]          cmd_src2_i,
    input  logic [ADDR_W-1:0]          cmd_dst_i,
    output logic                       req_valid_o,
    input  logic                       req_ready_i,
    output logic [OPCODE_W-1:0]        req_opcode_o,
    output logic [ADDR_W-1:0]          req_src0_o,
    output logic [ADDR_W-1:0]          req_src1_o,
    output logic [ADDR_W-1:0]          req_src2_o,
    output logic [ADDR_W-1:0]          req_dst_o,
    input  logic                       done_i,
    output logic                       busy_o,
    output logic [$clog2(DEPTH+1)-1:0] cmd_count_o
`ifdef VPU_CMD_TIMEOUT_EN
    ,
    output logic                       err_timeout_o
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = 1;

    typedef struct packed {
        logic [OPCODE_W-1:0] opcode;
        logic [ADDR_W-1:0]   src0;
        logic [ADDR_W-1:0]   src1;
        logic [ADDR_W-1:0]   src2;
        logic [ADDR_W-1:0]   dst;
    } cmd_t;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t         state;
    cmd_t           cmd_dat;
    cmd_t           head_dat;
    cmd_t           req_q;
    cmd_t           mem [DEPTH];
    logic [PTR_W:0] wr_ptr;
    logic [PTR_W:0] rd_ptr;
    logic [PTR_W:0] count;
    logic           fifo_full;
    logic           head_vld;
    logic           push;
    logic           pop;

    assign cmd_dat = {cmd_opcode_i, cmd_src0_i, cmd_src1_i, cmd_src2_i, cmd_dst_i};

    // Extra wrap bit on each pointer separates full from empty when the indices match.
    assign count     = wr_ptr - rd_ptr;
    assign fifo_full = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                       (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign head_vld  = (wr_ptr != rd_ptr);
    assign head_dat  = mem[rd_ptr[PTR_W-1:0]];

    assign push = cmd_valid_i & cmd_ready_o;
    assign pop  = head_vld & ((state == S_IDLE) | ((state == S_WAIT) & done_i));

    // Gated by rst_n so every output reads 0 while reset is held.
    assign cmd_ready_o = rst_n & ~fifo_full;
    assign cmd_count_o = count;
    assign busy_o      = (state != S_IDLE) | head_vld;

    assign req_opcode_o = req_q.opcode;
    assign req_src0_o   = req_q.src0;
    assign req_src1_o   = req_q.src1;
    assign req_src2_o   = req_q.src2;
    assign req_dst_o    = req_q.dst;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[PTR_W-1:0]] <= cmd_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

`ifdef VPU_CMD_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [TO_W-1:0] TO_ONE  = 1;

    logic [TO_W-1:0] wait_cnt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            req_valid_o <= 1'b0;
            req_q       <= '0;
`ifdef VPU_CMD_TIMEOUT_EN
            wait_cnt      <= '0;
            err_timeout_o <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (head_vld) begin
                        req_q       <= head_dat;
                        req_valid_o <= 1'b1;
                        state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (req_ready_i) begin
                        req_valid_o <= 1'b0;
                        state       <= S_WAIT;
`ifdef VPU_CMD_TIMEOUT_EN
                        wait_cnt <= '0;
`endif
                    end
                end
                S_WAIT: begin
                    // done_i has priority over the watchdog expiring in the same cycle.
                    if (done_i) begin
                        if (head_vld) begin
                            req_q       <= head_dat;
                            req_valid_o <= 1'b1;
                            state       <= S_ISSUE;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
`ifdef VPU_CMD_TIMEOUT_EN
                    else if (wait_cnt == TO_LAST) begin
                        err_timeout_o <= 1'b1;
                        state         <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + TO_ONE;
                    end
`endif
                end
                default: begin
                    state       <= S_IDLE;
                    req_valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vpu_cmd_dispatcher.sv
// Directed bench for vpu_cmd_dispatcher: reset, single issue, full FIFO, back-to-back, stall, mid-run reset.
// The watchdog scenario is compiled in when VPU_CMD_TIMEOUT_EN is defined (TIMEOUT_CYC=16).
module tb_vpu_cmd_dispatcher;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [7:0]  cmd_opcode_i;
    logic [15:0] cmd_src0_i;
    logic [15:0] cmd_src1_i;
    logic [15:0] cmd_src2_i;
    logic [15:0] cmd_dst_i;
    logic        req_valid_o;
    logic        req_ready_i;
    logic [7:0]  req_opcode_o;
    logic [15:0] req_src0_o;
    logic [15:0] req_src1_o;
    logic [15:0] req_src2_o;
    logic [15:0] req_dst_o;
    logic        done_i;
    logic        busy_o;
    logic [2:0]  cmd_count_o;
`ifdef VPU_CMD_TIMEOUT_EN
    logic        err_timeout_o;
`endif

    int checks   = 0;
    int failures = 0;

    vpu_cmd_dispatcher #(
        .DEPTH(4),
        .OPCODE_W(8),
        .ADDR_W(16)
`ifdef VPU_CMD_TIMEOUT_EN
        ,
        .TIMEOUT_CYC(16)
`endif
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cmd_valid_i(cmd_valid_i),
        .cmd_ready_o(cmd_ready_o),
        .cmd_opcode_i(cmd_opcode_i),
        .cmd_src0_i(cmd_src0_i),
        .cmd_src1_i(cmd_src1_i),
        .cmd_src2_i(cmd_src2_i),
        .cmd_dst_i(cmd_dst_i),
        .req_valid_o(req_valid_o),
        .req_ready_i(req_ready_i),
        .req_opcode_o(req_opcode_o),
        .req_src0_o(req_src0_o),
        .req_src1_o(req_src1_o),
        .req_src2_o(req_src2_o),
        .req_dst_o(req_dst_o),
        .done_i(done_i),
        .busy_o(busy_o),
        .cmd_count_o(cmd_count_o)
`ifdef VPU_CMD_TIMEOUT_EN
        ,
        .err_timeout_o(err_timeout_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL global_timeout simulation did not finish checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    // Advance n rising edges, landing 1 time unit after the last one.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_cmd(input logic [7:0] op, input logic [15:0] base);
        cmd_opcode_i = op;
        cmd_src0_i   = base;
        cmd_src1_i   = base + 16'd1;
        cmd_src2_i   = base + 16'd2;
        cmd_dst_i    = base + 16'd3;
    endtask

    task automatic push(input logic [7:0] op, input logic [15:0] base);
        set_cmd(op, base);
        cmd_valid_i = 1'b1;
        step(1);
        cmd_valid_i = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        step(2);
        checks++; if (req_valid_o !== 1'b0) begin failures++; $display("FAIL rst_req_valid got=%0b exp=0", req_valid_o); end
        checks++; if (cmd_ready_o !== 1'b0) begin failures++; $display("FAIL rst_cmd_ready got=%0b exp=0", cmd_ready_o); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0b exp=0", busy_o); end
        checks++; if (cmd_count_o !== 3'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", cmd_count_o); end
        checks++; if ({req_opcode_o, req_src0_o, req_dst_o} !== 40'h0) begin failures++; $display("FAIL rst_req_data got=%h exp=0", {req_opcode_o, req_src0_o, req_dst_o}); end
        rst_n = 1'b1;
        #1;
        checks++; if (cmd_ready_o !== 1'b1) begin failures++; $display("FAIL rst_release_ready got=%0b exp=1", cmd_ready_o); end
        step(1);
    endtask

    task automatic test_single;
        req_ready_i = 1'b1;
        push(8'h11, 16'h1000);
        checks++; if (cmd_count_o !== 3'd1) begin failures++; $display("FAIL single_stored_count got=%0d exp=1", cmd_count_o); end
        checks++; if (req_valid_o !== 1'b0) begin failures++; $display("FAIL single_no_bypass got=%0b exp=0", req_valid_o); end
        checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL single_busy_queued got=%0b exp=1", busy_o); end
        step(1);
        checks++; if (req_valid_o !== 1'b1) begin failures++; $display("FAIL single_issue_valid got=%0b exp=1", req_valid_o); end
        checks++; if (req_opcode_o !== 8'h11) begin failures++; $display("FAIL single_issue_opcode got=%h exp=11", req_opcode_o); end
        checks++; if ({req_src0_o, req_src1_o, req_src2_o, req_dst_o} !== 64'h1000_1001_1002_1003) begin failures++; $display("FAIL single_issue_addr got=%h exp=1000100110021003", {req_src0_o, req_src1_o, req_src2_o, req_dst_o}); end
        checks++; if (cmd_count_o !== 3'd0) begin failures++; $display("FAIL single_pop_count got=%0d exp=0", cmd_count_o); end
        step(1);
        checks++; if (req_valid_o !== 1'b0) begin failures++; $display("FAIL single_valid_one_cycle got=%0b exp=0", req_valid_o); end
        step(5);
        checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL single_busy_wait got=%0b exp=1", busy_o); end
        done_i = 1'b1;
        step(1);
        done_i = 1'b0;
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL single_busy_after_done got=%0b exp=0", busy_o); end
        checks++; if (req_opcode_o !== 8'h11) begin failures++; $display("FAIL single_hold_opcode got=%h exp=11", req_opcode_o); end
        // A completion pulse while idle must not change anything.
        done_i = 1'b1;
        step(1);
        done_i = 1'b0;
        checks++; if ({busy_o, req_valid_o} !== 2'b00) begin failures++; $display("FAIL single_idle_done got=%b exp=00", {busy_o, req_valid_o}); end
    endtask

    task automatic test_full;
        int exp_cnt [5];
        exp_cnt = '{1, 1, 2, 3, 4};
        req_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_cmd(8'(8'h21 + i), 16'(16'h2000 + 16 * i));
            cmd_valid_i = 1'b1;
            checks++; if (cmd_ready_o !== 1'b1) begin failures++; $display("FAIL full_ready_before_push%0d got=%0b exp=1", i, cmd_ready_o); end
            step(1);
            checks++; if (cmd_count_o !== 3'(exp_cnt[i])) begin failures++; $display("FAIL full_count_push%0d got=%0d exp=%0d", i, cmd_count_o, exp_cnt[i]); end
        end
        cmd_valid_i = 1'b0;
        checks++; if (cmd_ready_o !== 1'b0) begin failures++; $display("FAIL full_ready_low got=%0b exp=0", cmd_ready_o); end
        checks++; if (req_opcode_o !== 8'h21) begin failures++; $display("FAIL full_first_issued got=%h exp=21", req_opcode_o); end
        set_cmd(8'h99, 16'h9900);
        cmd_valid_i = 1'b1;
        step(2);
        cmd_valid_i = 1'b0;
        checks++; if (cmd_count_o !== 3'd4) begin failures++; $display("FAIL full_push_blocked got=%0d exp=4", cmd_count_o); end
        req_ready_i = 1'b1;
        step(1);
        checks++; if (req_valid_o !== 1'b0) begin failures++; $display("FAIL full_handshake got=%0b exp=0", req_valid_o); end
        for (int j = 1; j < 5; j++) begin
            done_i = 1'b1;
            step(1);
            done_i = 1'b0;
            checks++; if ({req_valid_o, req_opcode_o} !== {1'b1, 8'(8'h21 + j)}) begin failures++; $display("FAIL full_drain%0d got=%0b/%h exp=1/%h", j, req_valid_o, req_opcode_o, 8'(8'h21 + j)); end
            checks++; if (cmd_count_o !== 3'(4 - j)) begin failures++; $display("FAIL full_drain_count%0d got=%0d exp=%0d", j, cmd_count_o, 4 - j); end
            step(1);
        end
        done_i = 1'b1;
        step(1);
        done_i = 1'b0;
        checks++; if ({busy_o, cmd_count_o} !== 4'b0000) begin failures++; $display("FAIL full_drained got=%b exp=0000", {busy_o, cmd_count_o}); end
    endtask

    task automatic test_back_to_back;
        req_ready_i = 1'b0;
        push(8'h11, 16'h3000);
        push(8'h22, 16'h3100);
        push(8'h33, 16'h3200);
        checks++; if ({req_valid_o, req_opcode_o, cmd_count_o} !== {1'b1, 8'h11, 3'd2}) begin failures++; $display("FAIL b2b_first got=%b exp=1_00010001_010", {req_valid_o, req_opcode_o, cmd_count_o}); end
        req_ready_i = 1'b1;
        step(3);
        done_i = 1'b1;
        step(1);
        done_i = 1'b0;
        checks++; if ({req_valid_o, req_opcode_o} !== {1'b1, 8'h22}) begin failures++; $display("FAIL b2b_second got=%0b/%h exp=1/22", req_valid_o, req_opcode_o); end
        checks++; if (req_src0_o !== 16'h3100) begin failures++; $display("FAIL b2b_second_src0 got=%h exp=3100", req_src0_o); end
        // done_i coinciding with the handshake is dropped.
        done_i = 1'b1;
        step(1);
        done_i = 1'b0;
        step(1);
        checks++; if ({req_valid_o, cmd_count_o} !== {1'b0, 3'd1}) begin failures++; $display("FAIL b2b_done_on_handshake got=%b exp=0001", {req_valid_o, cmd_count_o}); end
        done_i = 1'b1;
        step(1);
        done_i = 1'b0;
        checks++; if ({req_valid_o, req_opcode_o, cmd_count_o} !== {1'b1, 8'h33, 3'd0}) begin failures++; $display("FAIL b2b_third got=%0b/%h/%0d exp=1/33/0", req_valid_o, req_opcode_o, cmd_count_o); end
        step(1);
        done_i = 1'b1;
        step(1);
        done_i = 1'b0;
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL b2b_idle got=%0b exp=0", busy_o); end
    endtask

    task automatic test_stall;
        logic stable;
        req_ready_i = 1'b0;
        push(8'h44, 16'h4000);
        step(1);
        stable = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if ({req_valid_o, req_opcode_o, req_src0_o, req_src1_o, req_src2_o, req_dst_o} !==
                {1'b1, 8'h44, 16'h4000, 16'h4001, 16'h4002, 16'h4003}) stable = 1'b0;
            step(1);
        end
        checks++; if (stable !== 1'b1) begin failures++; $display("FAIL stall_hold got=%0b exp=1 (last %0b/%h/%h)", stable, req_valid_o, req_opcode_o, req_dst_o); end
        req_ready_i = 1'b1;
        step(1);
        checks++; if ({req_valid_o, req_opcode_o} !== {1'b0, 8'h44}) begin failures++; $display("FAIL stall_handshake got=%0b/%h exp=0/44", req_valid_o, req_opcode_o); end
        done_i = 1'b1;
        step(1);
        done_i = 1'b0;
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL stall_idle got=%0b exp=0", busy_o); end
    endtask

    task automatic test_reset_mid;
        req_ready_i = 1'b0;
        push(8'h51, 16'h5000);
        push(8'h52, 16'h5100);
        push(8'h53, 16'h5200);
        req_ready_i = 1'b1;
        step(1);
        req_ready_i = 1'b0;
        checks++; if ({req_valid_o, cmd_count_o} !== {1'b0, 3'd2}) begin failures++; $display("FAIL rmid_setup got=%b exp=0010", {req_valid_o, cmd_count_o}); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if ({req_valid_o, busy_o, cmd_ready_o, cmd_count_o} !== 6'b0) begin failures++; $display("FAIL rmid_ctrl got=%b exp=000000", {req_valid_o, busy_o, cmd_ready_o, cmd_count_o}); end
        checks++; if ({req_opcode_o, req_src0_o, req_src1_o, req_src2_o, req_dst_o} !== 72'h0) begin failures++; $display("FAIL rmid_data got=%h exp=0", {req_opcode_o, req_src0_o, req_dst_o}); end
        step(2);
        rst_n = 1'b1;
        step(5);
        checks++; if ({req_valid_o, busy_o, cmd_count_o} !== 5'b0) begin failures++; $display("FAIL rmid_after got=%b exp=00000", {req_valid_o, busy_o, cmd_count_o}); end
        checks++; if (req_opcode_o !== 8'h00) begin failures++; $display("FAIL rmid_nothing_issued got=%h exp=00", req_opcode_o); end
    endtask

`ifdef VPU_CMD_TIMEOUT_EN
    task automatic test_timeout;
        req_ready_i = 1'b0;
        push(8'h61, 16'h6000);
        push(8'h62, 16'h6100);
        req_ready_i = 1'b1;
        step(1);
        req_ready_i = 1'b0;
        step(15);
        checks++; if ({err_timeout_o, req_valid_o, cmd_count_o} !== {1'b0, 1'b0, 3'd1}) begin failures++; $display("FAIL to_before got=%b exp=00001", {err_timeout_o, req_valid_o, cmd_count_o}); end
        step(1);
        checks++; if ({err_timeout_o, req_valid_o} !== 2'b10) begin failures++; $display("FAIL to_fire got=%b exp=10", {err_timeout_o, req_valid_o}); end
        step(1);
        checks++; if ({req_valid_o, req_opcode_o, cmd_count_o} !== {1'b1, 8'h62, 3'd0}) begin failures++; $display("FAIL to_next_issue got=%0b/%h/%0d exp=1/62/0", req_valid_o, req_opcode_o, cmd_count_o); end
        req_ready_i = 1'b1;
        step(1);
        req_ready_i = 1'b0;
        done_i = 1'b1;
        step(1);
        done_i = 1'b0;
        checks++; if ({err_timeout_o, busy_o} !== 2'b10) begin failures++; $display("FAIL to_sticky got=%b exp=10", {err_timeout_o, busy_o}); end
    endtask
`endif

    initial begin
        rst_n        = 1'b0;
        cmd_valid_i  = 1'b0;
        req_ready_i  = 1'b0;
        done_i       = 1'b0;
        cmd_opcode_i = '0;
        cmd_src0_i   = '0;
        cmd_src1_i   = '0;
        cmd_src2_i   = '0;
        cmd_dst_i    = '0;
        test_reset();
        test_single();
        test_full();
        test_back_to_back();
        test_stall();
        test_reset_mid();
`ifdef VPU_CMD_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
